// File: rtl/pulse_period_meter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// pulse_period_meter : counts clk cycles between rising edges of sig_in and
//                      reports each interval on a valid/ready output.
// Revision: 1.0
// -----------------------------------------------------------------------------
module pulse_period_meter #(
  parameter int N           = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sig_in,
  input  logic         enable,
  output logic [N-1:0] period,
  output logic         period_valid,
  input  logic         period_ready,
  output logic         overflow,
  output logic         dropped
);

  localparam logic [N-1:0] c_max_count = '1;
  localparam logic [N-1:0] c_one       = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_t;

  state_t                 state_q,    state_d;
  logic [SYNC_STAGES-1:0] sync_q,     sync_d;
  logic                   s_prev_q,   s_prev_d;
  logic [N-1:0]           count_q,    count_d;
  logic [N-1:0]           period_q,   period_d;
  logic                   valid_q,    valid_d;
  logic                   overflow_q, overflow_d;
  logic                   dropped_q,  dropped_d;
  logic                   w_rise;
  logic                   w_capture;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], sig_in};
    s_prev_d  = sync_q[SYNC_STAGES-1];
    w_rise    = sync_q[SYNC_STAGES-1] & ~s_prev_q;
    state_d   = state_q;
    count_d   = count_q;
    w_capture = 1'b0;

    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        if (enable) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (!enable) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (w_rise) begin
          state_d = ST_MEASURE;
          count_d = c_one;
        end
      end
      ST_MEASURE: begin
        if (!enable) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (w_rise) begin
          // Every edge closes one interval and opens the next.
          w_capture = 1'b1;
          count_d   = c_one;
        end else if (count_q != c_max_count) begin
          count_d = count_q + c_one;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase

    period_d   = period_q;
    overflow_d = overflow_q;
    valid_d    = valid_q;
    dropped_d  = dropped_q;
    if (w_capture) begin
      if (!valid_q || period_ready) begin
        period_d   = count_q;
        overflow_d = (count_q == c_max_count);
        valid_d    = 1'b1;
      end else begin
        dropped_d = 1'b1;
      end
    end else if (valid_q && period_ready) begin
      valid_d = 1'b0;
    end
    if (!enable) dropped_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sync_q     <= '0;
      s_prev_q   <= 1'b0;
      count_q    <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      s_prev_q   <= s_prev_d;
      count_q    <= count_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      dropped_q  <= dropped_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign overflow     = overflow_q;
  assign dropped      = dropped_q;

endmodule
`default_nettype wire

// File: doc/pulse_period_meter.md
Name: pulse_period_meter

Overview:
Receive-side companion to the team's counter/divider pulse generators. Measures the number of clk cycles between successive rising edges of an external or divided signal and presents each measurement on a valid/ready output. Used to check divider outputs and measure incoming tone/clock frequencies on the board.

Parameters:
N, 16, width of the period counter and result; the largest reportable period is 2^N-1 cycles.
SYNC_STAGES, 2, number of flip-flops in the sig_in synchronizer; minimum 2.

Ports:
clk  input  1  system clock; all logic is on its rising edge.
rst  input  1  reset, asynchronous, active-high.
sig_in  input  1  signal being measured; may be asynchronous to clk.
enable  input  1  1 = measure, 0 = idle.
period  output  N  last captured period, in clk cycles.
period_valid  output  1  period/overflow hold a measurement not yet accepted.
period_ready  input  1  consumer accepts when period_valid && period_ready.
overflow  output  1  qualifies period; 1 = true period is at least 2^N-1 cycles (saturated).
dropped  output  1  sticky; at least one measurement was discarded because of backpressure.

Behaviour:
- Reset (async assert, takes effect immediately with no clk edge): state=IDLE, counter=0, synchronizer and edge registers=0, period=0, period_valid=0, overflow=0, dropped=0.
- Synchronizer: sig_in passes through SYNC_STAGES flops to give s. One more register holds s_prev. rise = s & ~s_prev, so each rise lasts exactly one cycle.
- Because the synchronizer resets to 0, a sig_in already high at reset release is detected as a rise. Only ARM can see it, and there it is the reference edge only.
- Synchronizer latency is identical for every edge, so it adds no error to the measured period.
- IDLE: ignore rise. If enable=1, go to ARM on the next edge. A rise in the same cycle as that transition is ignored.
- ARM: on rise, set counter=1 and go to MEASURE.
- MEASURE, cycle without rise: counter <= counter+1, saturating at 2^N-1.
- MEASURE, cycle with rise: capture (counter, counter==2^N-1), set counter=1, stay in MEASURE. Measurement is continuous, so every edge both ends one interval and starts the next.
- Capture result: a square wave of period P cycles gives period=P for P <= 2^N-2. For P >= 2^N-1 it gives period=2^N-1 with overflow=1.
- Minimum measurable period is 2; a rise cannot occur on consecutive cycles.
- enable=0 in ARM or MEASURE: go to IDLE on the next edge and clear the counter. The in-progress interval is discarded and produces no capture.
- After re-enable, a result requires two fresh rises.
- Output handshake:
  - A capture with period_valid=0 loads period/overflow and sets period_valid=1 on the next edge.
  - period_valid=1 && period_ready=1 with no capture: period_valid <= 0.
  - Capture in the same cycle as an accepted transfer: new values load and period_valid stays 1.
  - Capture while period_valid=1 && period_ready=0: new values discarded, period/overflow held stable, dropped <= 1.
  - period/overflow never change while period_valid=1 and not accepted.
- A pending valid result survives enable=0 and remains until accepted.
- dropped clears only on rst, or on any cycle with enable=0.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- N=8, SYNC_STAGES=2, rst pulse, enable=1, period_ready=1, sig_in 5 high/5 low for 6 periods -> first period_valid one cycle after the 2nd synchronized rise. Five results: period=10, overflow=0, dropped=0.
- N=8, sig_in period 300 cycles -> period=255, overflow=1. Then switch to period 200 -> after the next full interval, period=200, overflow=0.
- period_ready=0, sig_in period 10 -> period_valid=1 with period=10, held constant; dropped=1 after the next rise. Raise period_ready for 1 cycle -> transfer, period_valid=0; next capture loads 10.
- Period 10, drop enable for 3 cycles mid-interval -> no result from the broken interval. After re-enable, the first result (period=10) appears only after two new rises. dropped cleared by the enable=0 cycle.
- Assert rst asynchronously between clk edges while period_valid=1 -> period, period_valid, overflow and dropped all 0 before the next clk edge. After release, normal measurement resumes.
- sig_in 1 high/1 low (period 2) and ready=1 throughout -> a result every 2 cycles, each period=2, no drops.
